// File: rtl/riscv_core_branch_pkg.sv
// Shared types and constants for the branch resolution / prediction controller.
package riscv_core_branch_pkg;

    // Controller sequencing states
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        FLUSH    = 2'd2
    } br_state_e;

    // 2-bit bimodal counter; MSB is the taken prediction
    typedef logic [1:0] bht_ctr_t;

    localparam bht_ctr_t SNT = 2'b00;
    localparam bht_ctr_t WNT = 2'b01;
    localparam bht_ctr_t WT  = 2'b10;
    localparam bht_ctr_t ST  = 2'b11;

    // Every counter starts weakly not-taken so one taken outcome flips it
    localparam bht_ctr_t BHT_RST = WNT;

endpackage

// File: rtl/riscv_core_bht.sv
// Bimodal branch history table: one combinational read port for fetch and
// one synchronous saturating-update port for training from execute.
module riscv_core_bht
    import riscv_core_branch_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic [1:0]       o_rd_ctr,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic             i_wr_taken
);

    bht_ctr_t ctr_q [ENTRIES];
    bht_ctr_t wr_old;
    bht_ctr_t wr_ctr_d;

    // Fetch read sees the pre-update value when it collides with a write
    assign o_rd_ctr = ctr_q[i_rd_idx];
    assign wr_old   = ctr_q[i_wr_idx];

    // Saturating increment on taken, saturating decrement on not-taken
    always_comb begin
        wr_ctr_d = wr_old;
        if (i_wr_taken) begin
            if (wr_old != ST) begin
                wr_ctr_d = wr_old + 2'd1;
            end
        end else begin
            if (wr_old != SNT) begin
                wr_ctr_d = wr_old - 2'd1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < ENTRIES; gi++) begin : g_ctr
            // Per-entry counter register with synchronous reset
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    ctr_q[gi] <= BHT_RST;
                end else if (i_wr_en && (i_wr_idx == IDX_W'(gi))) begin
                    ctr_q[gi] <= wr_ctr_d;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/riscv_core_branch_ctrl.sv
// Branch controller: predicts direction for fetch from the BHT, accepts
// resolved branches from execute, trains the BHT, and on a direction
// mispredict sequences a one-cycle redirect plus a fixed-length flush.
module riscv_core_branch_ctrl
    import riscv_core_branch_pkg::*;
#(
    parameter int XLEN         = 64,
    parameter int BHT_ENTRIES  = 64,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [XLEN-1:0] i_branch_ctrl_fetch_pc,
    output logic            o_branch_ctrl_predict_taken,
    input  logic            i_branch_ctrl_res_valid,
    output logic            o_branch_ctrl_res_ready,
    input  logic [XLEN-1:0] i_branch_ctrl_res_pc,
    input  logic            i_branch_ctrl_res_isbranch,
    input  logic            i_branch_ctrl_res_isjump,
    input  logic            i_branch_ctrl_res_istaken,
    input  logic            i_branch_ctrl_res_pred_taken,
    input  logic            i_branch_ctrl_res_is_rvc,
    input  logic [XLEN-1:0] i_branch_ctrl_res_target,
    output logic            o_branch_ctrl_redirect,
    output logic [XLEN-1:0] o_branch_ctrl_redirect_pc,
    output logic            o_branch_ctrl_flush,
    output logic [31:0]     o_branch_ctrl_mispredict_cnt
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);
    // Counter only needs to hold FLUSH_CYCLES-2 (cycles remaining after the first FLUSH cycle)
    localparam int CNT_W = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'((FLUSH_CYCLES > 1) ? (FLUSH_CYCLES - 2) : 0);

    br_state_e        state_q;
    logic             redirect_q;
    logic [XLEN-1:0]  redirect_pc_q;
    logic             flush_q;
    logic             ready_q;
    logic [CNT_W-1:0] flush_cnt_q;
    logic [31:0]      mispredict_cnt_q;

    logic             accept;
    logic             actual;
    logic             mispredict;
    logic             train;
    logic [XLEN-1:0]  seq_pc;
    logic [XLEN-1:0]  correct_pc;
    logic [1:0]       fetch_ctr;

    // Resolution evaluation; a branch+jump combination resolves as a jump
    always_comb begin
        accept     = i_branch_ctrl_res_valid & ready_q;
        actual     = i_branch_ctrl_res_isjump |
                     (i_branch_ctrl_res_isbranch & i_branch_ctrl_res_istaken);
        mispredict = (i_branch_ctrl_res_isbranch | i_branch_ctrl_res_isjump) &
                     (actual != i_branch_ctrl_res_pred_taken);
        train      = accept & i_branch_ctrl_res_isbranch & ~i_branch_ctrl_res_isjump;
        seq_pc     = i_branch_ctrl_res_pc +
                     (i_branch_ctrl_res_is_rvc ? XLEN'(2) : XLEN'(4));
        correct_pc = actual ? i_branch_ctrl_res_target : seq_pc;
    end

    riscv_core_bht #(
        .ENTRIES (BHT_ENTRIES),
        .IDX_W   (IDX_W)
    ) u_bht (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_rd_idx   (i_branch_ctrl_fetch_pc[IDX_W:1]),
        .o_rd_ctr   (fetch_ctr),
        .i_wr_en    (train),
        .i_wr_idx   (i_branch_ctrl_res_pc[IDX_W:1]),
        .i_wr_taken (actual)
    );

    assign o_branch_ctrl_predict_taken = fetch_ctr[1];

    // Redirect/flush sequencer with registered outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= IDLE;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            flush_q       <= 1'b0;
            ready_q       <= 1'b1;
            flush_cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept && mispredict) begin
                        state_q       <= REDIRECT;
                        redirect_q    <= 1'b1;
                        redirect_pc_q <= correct_pc;
                        flush_q       <= 1'b1;
                        ready_q       <= 1'b0;
                    end
                end
                REDIRECT: begin
                    redirect_q <= 1'b0;
                    if (FLUSH_CYCLES > 1) begin
                        state_q     <= FLUSH;
                        flush_cnt_q <= FLUSH_LOAD;
                    end else begin
                        state_q <= IDLE;
                        flush_q <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                FLUSH: begin
                    if (flush_cnt_q == '0) begin
                        state_q <= IDLE;
                        flush_q <= 1'b0;
                        ready_q <= 1'b1;
                    end else begin
                        flush_cnt_q <= flush_cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    redirect_q <= 1'b0;
                    flush_q    <= 1'b0;
                    ready_q    <= 1'b1;
                end
            endcase
        end
    end

    // Saturating count of accepted mispredicts
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mispredict_cnt_q <= '0;
        end else if (accept && mispredict && (mispredict_cnt_q != 32'hFFFF_FFFF)) begin
            mispredict_cnt_q <= mispredict_cnt_q + 32'd1;
        end
    end

    assign o_branch_ctrl_res_ready      = ready_q;
    assign o_branch_ctrl_redirect       = redirect_q;
    assign o_branch_ctrl_redirect_pc    = redirect_pc_q;
    assign o_branch_ctrl_flush          = flush_q;
    assign o_branch_ctrl_mispredict_cnt = mispredict_cnt_q;

endmodule

// File: tb/tb_riscv_core_branch_ctrl.sv
// Directed bench for riscv_core_branch_ctrl (FLUSH_CYCLES=2 main instance,
// FLUSH_CYCLES=1 secondary instance sharing the resolution inputs).
module tb_riscv_core_branch_ctrl;

    logic        clk;
    logic        rst;
    logic [63:0] fetch_pc;
    logic        res_valid;
    logic        res_valid1;
    logic [63:0] res_pc;
    logic        isbranch;
    logic        isjump;
    logic        istaken;
    logic        pred_taken;
    logic        is_rvc;
    logic [63:0] target;

    logic        predict, ready, redirect, flush;
    logic [63:0] redirect_pc;
    logic [31:0] mcnt;

    logic        predict1, ready1, redirect1, flush1;
    logic [63:0] redirect_pc1;
    logic [31:0] mcnt1;

    int tests;
    int fails;

    riscv_core_branch_ctrl #(.XLEN(64), .BHT_ENTRIES(64), .FLUSH_CYCLES(2)) dut (
        .i_clk                        (clk),
        .i_rst                        (rst),
        .i_branch_ctrl_fetch_pc       (fetch_pc),
        .o_branch_ctrl_predict_taken  (predict),
        .i_branch_ctrl_res_valid      (res_valid),
        .o_branch_ctrl_res_ready      (ready),
        .i_branch_ctrl_res_pc         (res_pc),
        .i_branch_ctrl_res_isbranch   (isbranch),
        .i_branch_ctrl_res_isjump     (isjump),
        .i_branch_ctrl_res_istaken    (istaken),
        .i_branch_ctrl_res_pred_taken (pred_taken),
        .i_branch_ctrl_res_is_rvc     (is_rvc),
        .i_branch_ctrl_res_target     (target),
        .o_branch_ctrl_redirect       (redirect),
        .o_branch_ctrl_redirect_pc    (redirect_pc),
        .o_branch_ctrl_flush          (flush),
        .o_branch_ctrl_mispredict_cnt (mcnt)
    );

    riscv_core_branch_ctrl #(.XLEN(64), .BHT_ENTRIES(64), .FLUSH_CYCLES(1)) dut1 (
        .i_clk                        (clk),
        .i_rst                        (rst),
        .i_branch_ctrl_fetch_pc       (fetch_pc),
        .o_branch_ctrl_predict_taken  (predict1),
        .i_branch_ctrl_res_valid      (res_valid1),
        .o_branch_ctrl_res_ready      (ready1),
        .i_branch_ctrl_res_pc         (res_pc),
        .i_branch_ctrl_res_isbranch   (isbranch),
        .i_branch_ctrl_res_isjump     (isjump),
        .i_branch_ctrl_res_istaken    (istaken),
        .i_branch_ctrl_res_pred_taken (pred_taken),
        .i_branch_ctrl_res_is_rvc     (is_rvc),
        .i_branch_ctrl_res_target     (target),
        .o_branch_ctrl_redirect       (redirect1),
        .o_branch_ctrl_redirect_pc    (redirect_pc1),
        .o_branch_ctrl_flush          (flush1),
        .o_branch_ctrl_mispredict_cnt (mcnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic resolve(input logic [63:0] pc, input logic br, input logic jp,
                           input logic tk, input logic pr, input logic rvc,
                           input logic [63:0] tgt);
        res_valid  = 1'b1;
        res_pc     = pc;
        isbranch   = br;
        isjump     = jp;
        istaken    = tk;
        pred_taken = pr;
        is_rvc     = rvc;
        target     = tgt;
        $display("[TB] t=%0t resolve pc=%0h br=%0b jp=%0b taken=%0b pred=%0b rvc=%0b tgt=%0h",
                 $time, pc, br, jp, tk, pr, rvc, tgt);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        fetch_pc = 64'h1000;
        res_valid = 1'b0;
        res_valid1 = 1'b0;
        res_pc = '0;
        isbranch = 1'b0;
        isjump = 1'b0;
        istaken = 1'b0;
        pred_taken = 1'b0;
        is_rvc = 1'b0;
        target = '0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_predict", 64'(predict), 64'd0);
        chk("rst_ready", 64'(ready), 64'd1);
        chk("rst_cnt", 64'(mcnt), 64'd0);
        chk("rst_flush", 64'(flush), 64'd0);
        chk("rst_redirect", 64'(redirect), 64'd0);
        chk("rst_redirect_pc", redirect_pc, 64'd0);

        // BEQ #1 taken at 0x1000, predicted not-taken: mispredict, counter 01->10
        resolve(64'h1000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 64'h2000);
        tick();
        res_valid = 1'b0;
        chk("beq1_redirect", 64'(redirect), 64'd1);
        chk("beq1_redirect_pc", redirect_pc, 64'h2000);
        chk("beq1_flush_a", 64'(flush), 64'd1);
        chk("beq1_ready_a", 64'(ready), 64'd0);
        chk("beq1_cnt", 64'(mcnt), 64'd1);
        tick();
        chk("beq1_flush_b", 64'(flush), 64'd1);
        chk("beq1_redirect_b", 64'(redirect), 64'd0);
        chk("beq1_ready_b", 64'(ready), 64'd0);
        tick();
        chk("beq1_flush_c", 64'(flush), 64'd0);
        chk("beq1_ready_c", 64'(ready), 64'd1);
        chk("beq1_predict", 64'(predict), 64'd1);

        // BEQ #2 taken, predicted not-taken: mispredict, counter 10->11
        resolve(64'h1000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 64'h2000);
        tick();
        res_valid = 1'b0;
        chk("beq2_redirect", 64'(redirect), 64'd1);
        tick();
        tick();
        // BEQ #3 taken, predicted taken: no mispredict
        resolve(64'h1000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 64'h2000);
        tick();
        res_valid = 1'b0;
        chk("beq3_redirect", 64'(redirect), 64'd0);
        chk("beq3_ready", 64'(ready), 64'd1);
        chk("beq3_cnt", 64'(mcnt), 64'd2);
        chk("beq3_predict", 64'(predict), 64'd1);

        // Train idx(0x3002)=1 up to 11 with correctly predicted taken RVC branches
        fetch_pc = 64'h3002;
        resolve(64'h3002, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 64'h8000);
        tick();
        resolve(64'h3002, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 64'h8000);
        tick();
        res_valid = 1'b0;
        chk("train3002_cnt", 64'(mcnt), 64'd2);
        chk("train3002_predict", 64'(predict), 64'd1);

        // RVC branch not taken, predicted taken: redirect to 0x3004, counter 11->10
        resolve(64'h3002, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 64'h9000);
        tick();
        chk("rvc_redirect", 64'(redirect), 64'd1);
        chk("rvc_redirect_pc", redirect_pc, 64'h3004);
        chk("rvc_cnt", 64'(mcnt), 64'd3);
        chk("rvc_predict", 64'(predict), 64'd1);

        // Next resolution held during REDIRECT/FLUSH must not be taken early
        fetch_pc = 64'h1004;
        resolve(64'h1004, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 64'hA000);
        #1;
        chk("hold_ready_redir", 64'(ready), 64'd0);
        chk("hold_predict_redir", 64'(predict), 64'd0);
        tick();
        chk("hold_ready_flush", 64'(ready), 64'd0);
        chk("hold_flush", 64'(flush), 64'd1);
        chk("hold_predict_flush", 64'(predict), 64'd0);
        tick();
        chk("hold_ready_idle", 64'(ready), 64'd1);
        chk("hold_predict_idle", 64'(predict), 64'd0);
        tick();
        res_valid = 1'b0;
        chk("hold_predict_after", 64'(predict), 64'd1);
        chk("hold_redirect_after", 64'(redirect), 64'd0);
        chk("hold_cnt_after", 64'(mcnt), 64'd3);

        // Not-taken at 0x3002 predicted correctly: 10->01 proves earlier decrement
        fetch_pc = 64'h3002;
        resolve(64'h3002, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 64'h9000);
        tick();
        res_valid = 1'b0;
        chk("dec3002_predict", 64'(predict), 64'd0);
        chk("dec3002_redirect", 64'(redirect), 64'd0);

        // JAL predicted taken: no redirect, BHT untouched
        fetch_pc = 64'h1008;
        resolve(64'h1008, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 64'h5000);
        tick();
        res_valid = 1'b0;
        chk("jal1_redirect", 64'(redirect), 64'd0);
        chk("jal1_ready", 64'(ready), 64'd1);
        chk("jal1_predict", 64'(predict), 64'd0);

        // JAL predicted not-taken: redirect to target, BHT untouched
        resolve(64'h1008, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h5000);
        tick();
        res_valid = 1'b0;
        chk("jal2_redirect", 64'(redirect), 64'd1);
        chk("jal2_redirect_pc", redirect_pc, 64'h5000);
        chk("jal2_cnt", 64'(mcnt), 64'd4);
        chk("jal2_predict", 64'(predict), 64'd0);
        tick();
        tick();

        // Reset during REDIRECT
        fetch_pc = 64'h100C;
        resolve(64'h100C, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 64'h6000);
        tick();
        res_valid = 1'b0;
        chk("rr_redirect", 64'(redirect), 64'd1);
        chk("rr_cnt", 64'(mcnt), 64'd5);
        chk("rr_predict_pre", 64'(predict), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rr_flush", 64'(flush), 64'd0);
        chk("rr_redirect_post", 64'(redirect), 64'd0);
        chk("rr_ready", 64'(ready), 64'd1);
        chk("rr_cnt_post", 64'(mcnt), 64'd0);
        chk("rr_redirect_pc", redirect_pc, 64'd0);
        chk("rr_predict_100c", 64'(predict), 64'd0);
        fetch_pc = 64'h1000;
        #1;
        chk("rr_predict_1000", 64'(predict), 64'd0);
        tick();
        chk("rr_flush_next", 64'(flush), 64'd0);

        // FLUSH_CYCLES=1 instance: ready low for exactly one cycle
        resolve(64'h1000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 64'h7000);
        res_valid  = 1'b0;
        res_valid1 = 1'b1;
        tick();
        res_valid1 = 1'b0;
        chk("f1_redirect", 64'(redirect1), 64'd1);
        chk("f1_redirect_pc", redirect_pc1, 64'h7000);
        chk("f1_flush", 64'(flush1), 64'd1);
        chk("f1_ready_low", 64'(ready1), 64'd0);
        chk("f1_main_untouched", 64'(redirect), 64'd0);
        tick();
        chk("f1_ready_back", 64'(ready1), 64'd1);
        chk("f1_flush_off", 64'(flush1), 64'd0);
        chk("f1_redirect_off", 64'(redirect1), 64'd0);
        chk("f1_cnt", 64'(mcnt1), 64'd1);
        chk("f1_predict", 64'(predict1), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
